// File: rtl/ddr_page_front_pkg.sv
// Shared opcode and state encodings for the page-oriented DDR front-end.
package ddr_page_front_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LA   = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_WRP  = 4'h3;
    localparam logic [3:0] OP_RDP  = 4'h4;
    localparam logic [3:0] OP_MODE = 4'h5;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

endpackage

// File: rtl/ddr_page_timer.sv
// Clearable saturating BUSY-cycle counter; expired_o flags the last allowed
// cycle so the FSM can leave BUSY on that same edge.
module ddr_page_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic gclk_i,
    input  logic grst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // Count enabled cycles, holding at TIMEOUT once reached.
    always_ff @(posedge gclk_i) begin
        if (grst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // cnt_q holds the number of BUSY cycles already completed, so this is the
    // TIMEOUT-th BUSY cycle when it equals TIMEOUT-1.
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ddr_page_front.sv
// Instruction front-end: decodes {opcode, imm8} into address/page registers
// and issues whole-page read/write requests over a req/ack handshake.
module ddr_page_front
    import ddr_page_front_pkg::*;
#(
    parameter int ADDR_BYTES = 4,
    parameter int PAGE_BYTES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                    gclk_i,
    input  logic                    grst_i,
    input  logic [11:0]             inst_i,
    input  logic                    inst_en_i,
    output logic [8*PAGE_BYTES-1:0] page_o,
    output logic                    ready_o,
    output logic                    error_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [8*ADDR_BYTES-1:0] mem_addr_o,
    output logic [8*PAGE_BYTES-1:0] mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic [8*PAGE_BYTES-1:0] mem_rdata_i
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int PW = 8 * PAGE_BYTES;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [PW-1:0] data_q;
    logic          autoinc_q;
    logic          we_q;
    logic          expired;

    logic [3:0] op;
    logic [7:0] imm;
    assign op  = inst_i[11:8];
    assign imm = inst_i[7:0];

    // Counter is held clear outside BUSY, so every request starts from zero.
    ddr_page_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .gclk_i    (gclk_i),
        .grst_i    (grst_i),
        .clr_i     (state_q != ST_BUSY),
        .en_i      (state_q == ST_BUSY),
        .expired_o (expired)
    );

    // Main FSM plus datapath registers; inst_en_i only matters in IDLE,
    // mem_ack_i only in BUSY, where ack takes priority over expiry.
    always_ff @(posedge gclk_i) begin
        if (grst_i) begin
            state_q   <= ST_RST;
            addr_q    <= '0;
            data_q    <= '0;
            autoinc_q <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_RST: state_q <= ST_IDLE;
                ST_IDLE: begin
                    if (inst_en_i) begin
                        case (op)
                            OP_NOP:  ;
                            OP_LA:   addr_q <= (addr_q << 8) | AW'(imm);
                            OP_LD:   data_q <= (data_q << 8) | PW'(imm);
                            OP_MODE: autoinc_q <= imm[0];
                            OP_WRP, OP_RDP: begin
                                we_q    <= (op == OP_WRP);
                                state_q <= ST_BUSY;
                            end
                            default: state_q <= ST_ERR;
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (mem_ack_i) begin
                        if (!we_q)     data_q <= mem_rdata_i;
                        if (autoinc_q) addr_q <= addr_q + AW'(1);
                        state_q <= ST_IDLE;
                    end else if (expired) begin
                        state_q <= ST_ERR;
                    end
                end
                default: state_q <= ST_ERR;
            endcase
        end
    end

    // Status and handshake outputs decode straight from the state register.
    assign ready_o     = (state_q == ST_IDLE);
    assign error_o     = (state_q == ST_ERR);
    assign mem_req_o   = (state_q == ST_BUSY);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = data_q;
    assign page_o      = data_q;

endmodule

// File: tb/tb_ddr_page_front.sv
// Directed bench: instance A uses defaults, instance B uses an 8-bit address
// and TIMEOUT=4 for the wrap and timeout scenarios.
module tb_ddr_page_front;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: defaults
    logic        a_rst, a_en, a_ack;
    logic [11:0] a_inst;
    logic [31:0] a_page, a_wdata, a_rdata, a_addr;
    logic        a_ready, a_error, a_req, a_we;

    ddr_page_front dut_a (
        .gclk_i(clk), .grst_i(a_rst), .inst_i(a_inst), .inst_en_i(a_en),
        .page_o(a_page), .ready_o(a_ready), .error_o(a_error),
        .mem_req_o(a_req), .mem_we_o(a_we), .mem_addr_o(a_addr),
        .mem_wdata_o(a_wdata), .mem_ack_i(a_ack), .mem_rdata_i(a_rdata)
    );

    // Instance B: 1-byte address, short timeout
    logic        b_rst, b_en, b_ack;
    logic [11:0] b_inst;
    logic [31:0] b_page, b_wdata, b_rdata;
    logic [7:0]  b_addr;
    logic        b_ready, b_error, b_req, b_we;

    ddr_page_front #(.ADDR_BYTES(1), .PAGE_BYTES(4), .TIMEOUT(4)) dut_b (
        .gclk_i(clk), .grst_i(b_rst), .inst_i(b_inst), .inst_en_i(b_en),
        .page_o(b_page), .ready_o(b_ready), .error_o(b_error),
        .mem_req_o(b_req), .mem_we_o(b_we), .mem_addr_o(b_addr),
        .mem_wdata_o(b_wdata), .mem_ack_i(b_ack), .mem_rdata_i(b_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_a(input logic [3:0] op, input logic [7:0] imm);
        int n = 0;
        while (!a_ready && n < 50) begin tick(); n++; end
        tests++;
        if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL issue_a_wait: ready=%b required 1 within 50 cycles", a_ready);
        end
        a_inst = {op, imm};
        a_en = 1'b1;
        tick();
        a_en = 1'b0;
    endtask

    task automatic issue_b(input logic [3:0] op, input logic [7:0] imm);
        int n = 0;
        while (!b_ready && n < 50) begin tick(); n++; end
        tests++;
        if (b_ready !== 1'b1) begin
            fails++;
            $display("FAIL issue_b_wait: ready=%b required 1 within 50 cycles", b_ready);
        end
        b_inst = {op, imm};
        b_en = 1'b1;
        tick();
        b_en = 1'b0;
    endtask

    // Back-end model for A: ack dly cycles after req is first seen.
    task automatic ack_a(input int dly, input logic [31:0] rd);
        int n = 0;
        while (!a_req && n < 50) begin tick(); n++; end
        tests++;
        if (a_req !== 1'b1) begin
            fails++;
            $display("FAIL ack_a_wait: mem_req=%b required 1 within 50 cycles", a_req);
        end
        repeat (dly - 1) tick();
        a_ack = 1'b1;
        a_rdata = rd;
        tick();
        a_ack = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({a_ready, a_error, a_req, a_we} !== 4'b0000 || a_page !== 32'h0 ||
            a_addr !== 32'h0 || a_wdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b err=%b req=%b we=%b page=%h addr=%h wdata=%h required all 0",
                     a_ready, a_error, a_req, a_we, a_page, a_addr, a_wdata);
        end
        a_rst = 1'b0;
        b_rst = 1'b0;
        tick();
        tests++;
        if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: ready=%b required 1", a_ready);
        end
    endtask

    task automatic test_write();
        issue_a(4'h1, 8'h12); issue_a(4'h1, 8'h3F);
        issue_a(4'h1, 8'h2B); issue_a(4'h1, 8'h00);
        issue_a(4'h2, 8'hAA); issue_a(4'h2, 8'hBB);
        issue_a(4'h2, 8'hCC); issue_a(4'h2, 8'hDD);
        tests++;
        if (a_page !== 32'hAABBCCDD) begin
            fails++;
            $display("FAIL ld_page: page=%h required aabbccdd", a_page);
        end
        issue_a(4'h3, 8'h00);
        tests++;
        if (a_req !== 1'b1 || a_we !== 1'b1 || a_addr !== 32'h123F2B00 || a_wdata !== 32'hAABBCCDD) begin
            fails++;
            $display("FAIL wrp_req: req=%b we=%b addr=%h wdata=%h required 1 1 123f2b00 aabbccdd",
                     a_req, a_we, a_addr, a_wdata);
        end
        ack_a(3, 32'h0);
        tests++;
        if (a_ready !== 1'b1 || a_req !== 1'b0) begin
            fails++;
            $display("FAIL wrp_done: ready=%b req=%b required 1 0", a_ready, a_req);
        end
    endtask

    task automatic test_read();
        repeat (4) issue_a(4'h2, 8'hEF);
        issue_a(4'h4, 8'h00);
        tests++;
        if (a_we !== 1'b0 || a_page !== 32'hEFEFEFEF || a_req !== 1'b1) begin
            fails++;
            $display("FAIL rdp_req: we=%b page=%h req=%b required 0 efefefef 1", a_we, a_page, a_req);
        end
        ack_a(3, 32'hAABBCCDD);
        tests++;
        if (a_page !== 32'hAABBCCDD || a_addr !== 32'h123F2B00 || a_ready !== 1'b1) begin
            fails++;
            $display("FAIL rdp_done: page=%h addr=%h ready=%b required aabbccdd 123f2b00 1",
                     a_page, a_addr, a_ready);
        end
    endtask

    task automatic test_autoinc();
        issue_a(4'h5, 8'h01);
        for (int i = 0; i < 3; i++) begin
            issue_a(4'h3, 8'h00);
            tests++;
            if (a_addr !== 32'h123F2B00 + i) begin
                fails++;
                $display("FAIL autoinc_addr%0d: addr=%h required %h", i, a_addr, 32'h123F2B00 + i);
            end
            ack_a(1, 32'h0);
        end
    endtask

    task automatic test_drop();
        a_inst = {4'h2, 8'h0A};
        a_en = 1'b0;
        tick();
        issue_a(4'h2, 8'h01);
        tests++;
        if (a_page !== 32'hBBCCDD01) begin
            fails++;
            $display("FAIL drop_inst_en: page=%h required bbccdd01", a_page);
        end
        issue_a(4'h3, 8'h00);
        a_inst = {4'h1, 8'h55};
        a_en = 1'b1;
        tick();
        a_en = 1'b0;
        tests++;
        if (a_addr !== 32'h123F2B03 || a_req !== 1'b1) begin
            fails++;
            $display("FAIL drop_la_busy: addr=%h req=%b required 123f2b03 1", a_addr, a_req);
        end
        ack_a(1, 32'h0);
        tests++;
        if (a_addr !== 32'h123F2B04) begin
            fails++;
            $display("FAIL busy_autoinc: addr=%h required 123f2b04", a_addr);
        end
        a_ack = 1'b1;
        a_rdata = 32'h11111111;
        tick();
        a_ack = 1'b0;
        tests++;
        if (a_page !== 32'hBBCCDD01 || a_addr !== 32'h123F2B04 || a_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_ack_ignored: page=%h addr=%h ready=%b required bbccdd01 123f2b04 1",
                     a_page, a_addr, a_ready);
        end
    endtask

    task automatic test_error();
        issue_a(4'hF, 8'h00);
        tests++;
        if (a_error !== 1'b1 || a_ready !== 1'b0 || a_req !== 1'b0) begin
            fails++;
            $display("FAIL bad_opcode: error=%b ready=%b req=%b required 1 0 0", a_error, a_ready, a_req);
        end
        a_inst = {4'h2, 8'hA0};
        a_en = 1'b1;
        tick();
        a_en = 1'b0;
        tests++;
        if (a_page !== 32'hBBCCDD01 || a_error !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: page=%h error=%b required bbccdd01 1", a_page, a_error);
        end
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        tests++;
        if (a_error !== 1'b0 || a_ready !== 1'b0 || a_page !== 32'h0 || a_addr !== 32'h0) begin
            fails++;
            $display("FAIL err_reset: error=%b ready=%b page=%h addr=%h required 0 0 0 0",
                     a_error, a_ready, a_page, a_addr);
        end
        tick();
        tests++;
        if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL err_release_ready: ready=%b required 1", a_ready);
        end
        issue_a(4'h2, 8'hAB);
        tests++;
        if (a_page !== 32'h000000AB) begin
            fails++;
            $display("FAIL post_reset_ld: page=%h required 000000ab", a_page);
        end
    endtask

    task automatic test_wrap();
        issue_b(4'h1, 8'hFF);
        issue_b(4'h5, 8'h01);
        issue_b(4'h3, 8'h00);
        tests++;
        if (b_addr !== 8'hFF || b_req !== 1'b1) begin
            fails++;
            $display("FAIL wrap_req: addr=%h req=%b required ff 1", b_addr, b_req);
        end
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        tests++;
        if (b_addr !== 8'h00 || b_ready !== 1'b1) begin
            fails++;
            $display("FAIL wrap_addr: addr=%h ready=%b required 00 1", b_addr, b_ready);
        end
    endtask

    task automatic test_timeout();
        issue_b(4'h3, 8'h00);
        for (int k = 1; k < 4; k++) begin
            tick();
            tests++;
            if (b_error !== 1'b0 || b_req !== 1'b1) begin
                fails++;
                $display("FAIL timeout_busy%0d: error=%b req=%b required 0 1", k, b_error, b_req);
            end
        end
        tick();
        tests++;
        if (b_error !== 1'b1 || b_ready !== 1'b0 || b_req !== 1'b0) begin
            fails++;
            $display("FAIL timeout_err: error=%b ready=%b req=%b required 1 0 0", b_error, b_ready, b_req);
        end
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        tick();
        issue_b(4'h3, 8'h00);
        repeat (3) tick();
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        tests++;
        if (b_error !== 1'b0 || b_ready !== 1'b1 || b_req !== 1'b0) begin
            fails++;
            $display("FAIL timeout_ack_wins: error=%b ready=%b req=%b required 0 1 0", b_error, b_ready, b_req);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_ack = 1'b0; a_inst = '0; a_rdata = '0;
        b_rst = 1'b1; b_en = 1'b0; b_ack = 1'b0; b_inst = '0; b_rdata = '0;
        repeat (3) tick();
        test_reset();
        test_write();
        test_read();
        test_autoinc();
        test_drop();
        test_error();
        test_wrap();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
